// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer between fetch and execute.
// Optional M-extension decode is enabled by defining DECODE_M_EXT_EN (needs ALU_CTRL_W >= 5).
module decode_stage #(
   parameter int              XLEN         = 32,
   parameter int              ALU_CTRL_W   = 4,
   parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [4:0]            out_rd,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [XLEN-1:0]       out_imm,
   output logic                  out_branch,
   output logic                  out_mem_rd,
   output logic                  out_mem_wr,
   output logic                  out_mem_to_reg,
   output logic                  out_r1_zero,
   output logic                  out_r1_pc,
   output logic                  out_jump,
   output logic                  out_alu_src,
   output logic                  out_reg_wr,
   output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
   output logic                  out_illegal
);

   if (XLEN < 32) begin : g_bad_xlen
      $error("decode_stage: XLEN must be >= 32");
   end
   if (ALU_CTRL_W < 4) begin : g_bad_alu_w
      $error("decode_stage: ALU_CTRL_W must be >= 4");
   end
`ifdef DECODE_M_EXT_EN
   if (ALU_CTRL_W < 5) begin : g_bad_alu_w_m
      $error("decode_stage: DECODE_M_EXT_EN requires ALU_CTRL_W >= 5");
   end
`endif

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [XLEN-1:0]       imm;
      logic                  branch;
      logic                  mem_rd;
      logic                  mem_wr;
      logic                  mem_to_reg;
      logic                  r1_zero;
      logic                  r1_pc;
      logic                  jump;
      logic                  alu_src;
      logic                  reg_wr;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic                  illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // state | meaning
   // EMPTY | nothing buffered, out_valid=0
   // ONE   | output register valid, skid empty
   // TWO   | output register and skid valid, in_ready=0

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
   assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign b_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign u_imm = {in_instr[31:12], 12'b0};
   assign j_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   bundle_t dec;
   logic    br, mrd, mwr, m2r, r1z, r1pc, jmp, asrc, rwr, ill;
   logic [ALU_CTRL_W-1:0] alu;
   logic [31:0]           imm32;

   always_comb begin
      br    = 1'b0;
      mrd   = 1'b0;
      mwr   = 1'b0;
      m2r   = 1'b0;
      r1z   = 1'b0;
      r1pc  = 1'b0;
      jmp   = 1'b0;
      asrc  = 1'b0;
      rwr   = 1'b0;
      ill   = 1'b0;
      alu   = '0;
      imm32 = '0;
      case (opcode)
         OP_R: begin
            if (funct7 == 7'b0000000 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               rwr = 1'b1;
               alu = ALU_CTRL_W'({in_instr[30], funct3});
            end
`ifdef DECODE_M_EXT_EN
            else if (funct7 == 7'b0000001) begin
               rwr = 1'b1;
               alu = ALU_CTRL_W'({1'b1, 1'b0, funct3});
            end
`endif
            else begin
               ill = 1'b1;
            end
         end
         OP_IMM: begin
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = i_imm;
            case (funct3)
               3'b001: begin
                  ill = (funct7 != 7'b0000000);
                  alu = ALU_CTRL_W'({1'b0, funct3});
               end
               3'b101: begin
                  ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                  alu = ALU_CTRL_W'({in_instr[30], funct3});
               end
               default: alu = ALU_CTRL_W'({1'b0, funct3});
            endcase
         end
         OP_LOAD: begin
            mrd   = 1'b1;
            m2r   = 1'b1;
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = i_imm;
         end
         OP_STORE: begin
            mwr   = 1'b1;
            asrc  = 1'b1;
            imm32 = s_imm;
         end
         OP_BRANCH: begin
            br    = 1'b1;
            imm32 = b_imm;
            alu   = ALU_CTRL_W'(4'b1000);
         end
         OP_LUI: begin
            r1z   = 1'b1;
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = u_imm;
         end
         OP_AUIPC: begin
            r1pc  = 1'b1;
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = u_imm;
         end
         OP_JAL: begin
            jmp   = 1'b1;
            r1pc  = 1'b1;
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = j_imm;
         end
         OP_JALR: begin
            jmp   = 1'b1;
            asrc  = 1'b1;
            rwr   = 1'b1;
            imm32 = i_imm;
            ill   = (funct3 != 3'b000);
         end
         default: ill = 1'b1;
      endcase

      dec     = '0;
      dec.pc  = in_pc;
      dec.rd  = in_instr[11:7];
      dec.rs1 = in_instr[19:15];
      dec.rs2 = in_instr[24:20];
      // An illegal word travels as a pure marker: no side-effecting control bits.
      if (ill) begin
         dec.illegal = 1'b1;
      end else begin
         dec.imm        = XLEN'($signed(imm32));
         dec.branch     = br;
         dec.mem_rd     = mrd;
         dec.mem_wr     = mwr;
         dec.mem_to_reg = m2r;
         dec.r1_zero    = r1z;
         dec.r1_pc      = r1pc;
         dec.jump       = jmp;
         dec.alu_src    = asrc;
         dec.reg_wr     = rwr;
         dec.alu_ctrl   = alu;
      end
   end

   function automatic bundle_t idle_bundle();
      bundle_t b;
      b    = '0;
      b.pc = RESET_PC_TAG;
      return b;
   endfunction

   state_t  state;
   bundle_t out_r;
   bundle_t skid_r;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_r     <= idle_bundle();
         skid_r    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  out_r     <= dec;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     out_r <= dec;
                  end else begin
                     out_r     <= idle_bundle();
                     out_valid <= 1'b0;
                     state     <= EMPTY;
                  end
               end else if (in_valid) begin
                  skid_r   <= dec;
                  in_ready <= 1'b0;
                  state    <= TWO;
               end
            end
            TWO: begin
               if (out_ready) begin
                  out_r    <= skid_r;
                  skid_r   <= '0;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_r     <= idle_bundle();
               skid_r    <= '0;
            end
         endcase
      end
   end

   assign out_pc         = out_r.pc;
   assign out_rd         = out_r.rd;
   assign out_rs1        = out_r.rs1;
   assign out_rs2        = out_r.rs2;
   assign out_imm        = out_r.imm;
   assign out_branch     = out_r.branch;
   assign out_mem_rd     = out_r.mem_rd;
   assign out_mem_wr     = out_r.mem_wr;
   assign out_mem_to_reg = out_r.mem_to_reg;
   assign out_r1_zero    = out_r.r1_zero;
   assign out_r1_pc      = out_r.r1_pc;
   assign out_jump       = out_r.jump;
   assign out_alu_src    = out_r.alu_src;
   assign out_reg_wr     = out_r.reg_wr;
   assign out_alu_ctrl   = out_r.alu_ctrl;
   assign out_illegal    = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued on accept and compared on pop.
module tb_decode_stage;
`ifdef DECODE_M_EXT_EN
   localparam int ACW = 5;
`else
   localparam int ACW = 4;
`endif
   localparam logic [31:0] TAG = 32'hDEAD_0000;

   localparam logic [8:0] BR   = 9'h100;
   localparam logic [8:0] MRD  = 9'h080;
   localparam logic [8:0] MWR  = 9'h040;
   localparam logic [8:0] M2R  = 9'h020;
   localparam logic [8:0] R1Z  = 9'h010;
   localparam logic [8:0] R1PC = 9'h008;
   localparam logic [8:0] JMP  = 9'h004;
   localparam logic [8:0] ASRC = 9'h002;
   localparam logic [8:0] RWR  = 9'h001;

   logic clk = 1'b0;
   logic reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic out_branch, out_mem_rd, out_mem_wr, out_mem_to_reg, out_r1_zero;
   logic out_r1_pc, out_jump, out_alu_src, out_reg_wr, out_illegal;
   logic [ACW-1:0] out_alu_ctrl;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ALU_CTRL_W(ACW), .RESET_PC_TAG(TAG)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_branch(out_branch), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_mem_to_reg(out_mem_to_reg), .out_r1_zero(out_r1_zero), .out_r1_pc(out_r1_pc),
      .out_jump(out_jump), .out_alu_src(out_alu_src), .out_reg_wr(out_reg_wr),
      .out_alu_ctrl(out_alu_ctrl), .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [31:0]    pc;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [31:0]    imm;
      logic [8:0]     ctrl;
      logic [ACW-1:0] alu;
      logic           ill;
   } exp_t;

   exp_t q[$];
   exp_t cur_exp;
   exp_t idle;
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                               input logic [8:0] ctrl, input int alu,
                               input logic [31:0] imm, input logic ill);
      exp_t r;
      r.pc   = pc;
      r.rd   = ins[11:7];
      r.rs1  = ins[19:15];
      r.rs2  = ins[24:20];
      r.imm  = imm;
      r.ctrl = ctrl;
      r.alu  = ACW'(alu);
      r.ill  = ill;
      return r;
   endfunction

   function automatic exp_t obs();
      exp_t r;
      r.pc   = out_pc;
      r.rd   = out_rd;
      r.rs1  = out_rs1;
      r.rs2  = out_rs2;
      r.imm  = out_imm;
      r.ctrl = {out_branch, out_mem_rd, out_mem_wr, out_mem_to_reg, out_r1_zero,
                out_r1_pc, out_jump, out_alu_src, out_reg_wr};
      r.alu  = out_alu_ctrl;
      r.ill  = out_illegal;
      return r;
   endfunction

   task automatic check_b(input string tag, input exp_t got, input exp_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Handshakes are evaluated from values settled since the last edge, then one clock passes.
   task automatic cycle(output bit accepted);
      exp_t e;
      accepted = in_valid && in_ready && !flush && !reset;
      if (!reset && !flush && out_valid && out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_pop observed=%h expected=none", obs());
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            check_b("bundle", obs(), e);
         end
      end
      if (accepted) q.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [8:0] ctrl,
                        input int alu, input logic [31:0] imm, input logic ill);
      in_instr = ins;
      in_pc    = pc;
      in_valid = 1'b1;
      cur_exp  = mk(pc, ins, ctrl, alu, imm, ill);
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [8:0] ctrl,
                       input int alu, input logic [31:0] imm, input logic ill, input bit rnd);
      bit acc;
      acc = 1'b0;
      drive(ins, pc, ctrl, alu, imm, ill);
      for (int k = 0; k < 50; k++) begin
         if (rnd) out_ready = ($urandom_range(0, 2) != 0);
         cycle(acc);
         if (acc) break;
      end
      check_1("accept_timeout", acc, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() != 0; k++) cycle(acc);
      checks++;
      assert (q.size() == 0) else begin
         errors++;
         $error("FAIL drain_timeout observed=%0d expected=0", q.size());
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_b(tag, obs(), idle);
      check_1({tag, "_in_ready"}, in_ready, 1'b1);
      check_1({tag, "_out_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      bit acc;
      idle      = '0;
      idle.pc   = TAG;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_instr  = '0;
      in_pc     = '0;
      cur_exp   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state("reset");

      // addi x1,x0,-5: one-cycle latency
      drive(32'hFFB00093, 32'h100, ASRC | RWR, 0, 32'hFFFFFFFB, 1'b0);
      cycle(acc);
      in_valid = 1'b0;
      check_1("addi_latency", out_valid, 1'b1);
      cycle(acc);
      check_1("addi_empty", out_valid, 1'b0);
      check_1("empty_pc_tag", out_pc === TAG, 1'b1);

      // sub then beq back to back
      drive(32'h40208033, 32'h104, RWR, 8, 32'h0, 1'b0);
      cycle(acc);
      drive(32'h00208463, 32'h108, BR, 8, 32'h8, 1'b0);
      cycle(acc);
      in_valid = 1'b0;
      check_1("b2b_valid", out_valid, 1'b1);
      cycle(acc);
      check_1("b2b_empty", out_valid, 1'b0);

      // Stall: fill both entries, offer a third while full
      out_ready = 1'b0;
      drive(32'h00812283, 32'h200, MRD | M2R | ASRC | RWR, 0, 32'h8, 1'b0);
      cycle(acc);
      check_1("ready_one", in_ready, 1'b1);
      drive(32'h00512623, 32'h204, MWR | ASRC, 0, 32'hC, 1'b0);
      cycle(acc);
      check_1("ready_two", in_ready, 1'b0);
      drive(32'hFFDFF0EF, 32'h208, JMP | R1PC | ASRC | RWR, 0, 32'hFFFFFFFC, 1'b0);
      cycle(acc);
      check_1("full_ignored", acc, 1'b0);
      check_b("stall_hold", obs(), q[0]);
      out_ready = 1'b1;
      cycle(acc);
      check_1("ready_after_pop", in_ready, 1'b1);
      cycle(acc);
      check_1("jal_accepted", acc, 1'b1);
      in_valid = 1'b0;
      drain();

      // Mixed stream with random backpressure, including illegal encodings
      send(32'h123451B7, 32'h300, R1Z | ASRC | RWR, 0, 32'h12345000, 1'b0, 1'b1);
      send(32'h0000007F, 32'h304, 9'h0, 0, 32'h0, 1'b1, 1'b1);
`ifdef DECODE_M_EXT_EN
      send(32'h02208033, 32'h308, RWR, 16, 32'h0, 1'b0, 1'b1);
`else
      send(32'h02208033, 32'h308, 9'h0, 0, 32'h0, 1'b1, 1'b1);
`endif
      send(32'h000090E7, 32'h30C, 9'h0, 0, 32'h0, 1'b1, 1'b1);
      send(32'h4030D113, 32'h310, ASRC | RWR, 13, 32'h403, 1'b0, 1'b1);
      send(32'h40309113, 32'h314, 9'h0, 0, 32'h0, 1'b1, 1'b1);
      send(32'h000080E7, 32'h318, JMP | ASRC | RWR, 0, 32'h0, 1'b0, 1'b1);
      drain();

      // Flush while full, with a same-cycle input that must be discarded
      out_ready = 1'b0;
      send(32'h00812283, 32'h400, MRD | M2R | ASRC | RWR, 0, 32'h8, 1'b0, 1'b0);
      send(32'h00512623, 32'h404, MWR | ASRC, 0, 32'hC, 1'b0, 1'b0);
      check_1("flush_pre_full", in_ready, 1'b0);
      flush     = 1'b1;
      out_ready = 1'b1;
      drive(32'hFFB00093, 32'h408, ASRC | RWR, 0, 32'hFFFFFFFB, 1'b0);
      cycle(acc);
      flush    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      check_reset_state("flush");
      repeat (3) cycle(acc);
      check_1("flush_quiet", out_valid, 1'b0);

      // Reset in the middle of a stall
      out_ready = 1'b0;
      send(32'h00812283, 32'h500, MRD | M2R | ASRC | RWR, 0, 32'h8, 1'b0, 1'b0);
      send(32'h00512623, 32'h504, MWR | ASRC, 0, 32'hC, 1'b0, 1'b0);
      reset = 1'b1;
      drive(32'h40208033, 32'h508, RWR, 8, 32'h0, 1'b0);
      cycle(acc);
      reset    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      check_reset_state("midreset");
      out_ready = 1'b1;
      repeat (2) cycle(acc);
      check_1("midreset_quiet", out_valid, 1'b0);

      send(32'hFFB00093, 32'h600, ASRC | RWR, 0, 32'hFFFFFFFB, 1'b0, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
